// File: rtl/uart_tx_arb_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_tx_arb_if                                         |
// | Description : Requester and transmitter signals of the line arbiter. |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface uart_tx_arb_if;
   logic       src0_vld;
   logic [7:0] src0_data;
   logic       src0_rd;
   logic       src1_vld;
   logic [7:0] src1_data;
   logic       src1_rd;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       tx_rd;
   logic       grant;
   logic       busy;

   modport master (
      output src0_vld, src0_data, src1_vld, src1_data, tx_rd,
      input  src0_rd, src1_rd, tx_ready, tx_data, grant, busy
   );

   modport slave (
      input  src0_vld, src0_data, src1_vld, src1_data, tx_rd,
      output src0_rd, src1_rd, tx_ready, tx_data, grant, busy
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_tx_arb                                            |
// | Description : Two-requester round-robin line arbiter for a UART TX;  |
// |               a grant is held until the line terminator is sent.     |
// |               Define ARB_TIMEOUT_EN to force-terminate stalled lines.|
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module uart_tx_arb #(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter logic [7:0]  NL_CHAR     = 8'h0a
) (
   input  logic         clk,
   input  logic         rst,
   uart_tx_arb_if.slave bus
);
   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_XFER   = 2'd1;
`ifdef ARB_TIMEOUT_EN
   localparam logic [1:0] c_INJ_NL = 2'd2;
   localparam int unsigned c_CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYC);
`endif

   logic [1:0] state_q, state_d;
   logic       grant_q, grant_d;
   logic       last_served_q, last_served_d;
`ifdef ARB_TIMEOUT_EN
   logic [c_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
`else
   // Without the timeout a stalled owner keeps the line; TIMEOUT_CYC is inert here.
   if (TIMEOUT_CYC > 0) begin : g_no_timeout
   end else begin : g_no_timeout_zero
   end
`endif

   logic       w_own_vld;
   logic [7:0] w_own_data;
   logic       w_own_xfer;
   logic       w_tx_ready;
   logic [7:0] w_tx_data;
   logic       w_src0_rd;
   logic       w_src1_rd;

   assign w_own_vld  = grant_q ? bus.src1_vld  : bus.src0_vld;
   assign w_own_data = grant_q ? bus.src1_data : bus.src0_data;
   assign w_own_xfer = w_own_vld & bus.tx_rd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= c_IDLE;
         grant_q       <= 1'b0;
         last_served_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
         idle_cnt_q    <= '0;
`endif
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_served_q <= last_served_d;
`ifdef ARB_TIMEOUT_EN
         idle_cnt_q    <= idle_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_served_d = last_served_q;
`ifdef ARB_TIMEOUT_EN
      idle_cnt_d    = idle_cnt_q;
`endif
      case (state_q)
         c_IDLE: begin
`ifdef ARB_TIMEOUT_EN
            idle_cnt_d = '0;
`endif
            if (bus.src0_vld || bus.src1_vld) begin
               state_d = c_XFER;
               // On contention the requester served less recently wins.
               if (bus.src0_vld && bus.src1_vld)
                  grant_d = ~last_served_q;
               else
                  grant_d = bus.src1_vld;
            end
         end
         c_XFER: begin
            if (w_own_xfer) begin
`ifdef ARB_TIMEOUT_EN
               idle_cnt_d = '0;
`endif
               if (w_own_data == NL_CHAR) begin
                  state_d       = c_IDLE;
                  last_served_d = grant_q;
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (!w_own_vld) begin
               idle_cnt_d = idle_cnt_q + 1'b1;
               if (idle_cnt_d >= c_TIMEOUT)
                  state_d = c_INJ_NL;
            end
`endif
         end
`ifdef ARB_TIMEOUT_EN
         c_INJ_NL: begin
            idle_cnt_d = '0;
            if (bus.tx_rd) begin
               state_d       = c_IDLE;
               last_served_d = grant_q;
            end
         end
`endif
         default: state_d = c_IDLE;
      endcase
   end

   always_comb begin
      w_tx_ready = 1'b0;
      w_tx_data  = 8'h00;
      w_src0_rd  = 1'b0;
      w_src1_rd  = 1'b0;
      case (state_q)
         c_XFER: begin
            w_tx_ready = w_own_vld;
            w_tx_data  = w_own_data;
            w_src0_rd  = ~grant_q & w_own_xfer;
            w_src1_rd  = grant_q & w_own_xfer;
         end
`ifdef ARB_TIMEOUT_EN
         c_INJ_NL: begin
            w_tx_ready = 1'b1;
            w_tx_data  = NL_CHAR;
         end
`endif
         default: ;
      endcase
   end

   assign bus.tx_ready = w_tx_ready;
   assign bus.tx_data  = w_tx_data;
   assign bus.src0_rd  = w_src0_rd;
   assign bus.src1_rd  = w_src1_rd;
   assign bus.grant    = grant_q;
   assign bus.busy     = (state_q != c_IDLE);
endmodule
`default_nettype wire
